// File: rtl/neander_ctrl.sv
// Neander control unit: Moore FSM sequencing fetch, decode, operand fetch and execute
// with registered strobes. Optional fetch single-step gate: define NEANDER_CTRL_STEP_EN.
module neander_ctrl #(
  parameter int OPW  = 4,
  parameter int SELW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  opcode,
  input  logic            flag_n,
  input  logic            flag_z,
`ifdef NEANDER_CTRL_STEP_EN
  input  logic            step,
  output logic            step_wait,
`endif
  output logic            pc_inc,
  output logic            pc_load,
  output logic            rem_load,
  output logic            rem_sel,
  output logic            rdm_load,
  output logic            rdm_sel,
  output logic            mem_write,
  output logic            ri_load,
  output logic            ac_load,
  output logic            nz_load,
  output logic [SELW-1:0] sel_ula,
  output logic            halted
);

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_STA = 4'b0001;
  localparam logic [3:0] OP_LDA = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b0110;
  localparam logic [3:0] OP_JMP = 4'b1000;
  localparam logic [3:0] OP_JN  = 4'b1001;
  localparam logic [3:0] OP_JZ  = 4'b1010;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [SELW-1:0] ULA_ADD  = SELW'(3'b000);
  localparam logic [SELW-1:0] ULA_AND  = SELW'(3'b001);
  localparam logic [SELW-1:0] ULA_OR   = SELW'(3'b010);
  localparam logic [SELW-1:0] ULA_NOT  = SELW'(3'b011);
  localparam logic [SELW-1:0] ULA_PASS = SELW'(3'b100);

  typedef enum logic [4:0] {
    S_F_ADDR  = 5'd0,
    S_F_READ  = 5'd1,
    S_F_RDM   = 5'd2,
    S_F_RI    = 5'd3,
    S_DECODE  = 5'd4,
    S_O_ADDR  = 5'd5,
    S_O_READ  = 5'd6,
    S_O_RDM   = 5'd7,
    S_D_ADDR  = 5'd8,
    S_D_READ  = 5'd9,
    S_D_RDM   = 5'd10,
    S_D_WDATA = 5'd11,
    S_D_WRITE = 5'd12,
    S_EXEC    = 5'd13,
    S_JUMP    = 5'd14,
    S_SKIP    = 5'd15,
    S_HALT    = 5'd16
  } state_t;

  typedef struct packed {
    logic pc_inc;
    logic pc_load;
    logic rem_load;
    logic rem_sel;
    logic rdm_load;
    logic rdm_sel;
    logic mem_write;
    logic ri_load;
    logic ac_load;
    logic nz_load;
    logic halted;
  } strobe_t;

  // Strobe pattern owned by each state.
  function automatic strobe_t state_strobes(input state_t s);
    strobe_t t;
    t = '0;
    case (s)
      S_F_ADDR:  t.rem_load  = 1'b1;
      S_F_READ:  t.pc_inc    = 1'b1;
      S_F_RDM:   t.rdm_load  = 1'b1;
      S_F_RI:    t.ri_load   = 1'b1;
      S_O_ADDR:  t.rem_load  = 1'b1;
      S_O_READ:  t.pc_inc    = 1'b1;
      S_O_RDM:   t.rdm_load  = 1'b1;
      S_D_ADDR: begin
        t.rem_load = 1'b1;
        t.rem_sel  = 1'b1;
      end
      S_D_RDM:   t.rdm_load  = 1'b1;
      S_D_WDATA: begin
        t.rdm_load = 1'b1;
        t.rdm_sel  = 1'b1;
      end
      S_D_WRITE: t.mem_write = 1'b1;
      S_EXEC: begin
        t.ac_load = 1'b1;
        t.nz_load = 1'b1;
      end
      S_JUMP:    t.pc_load   = 1'b1;
      S_SKIP:    t.pc_inc    = 1'b1;
      S_HALT:    t.halted    = 1'b1;
      default:   t = '0;
    endcase
    return t;
  endfunction

  // ULA operation for the instruction in RI; non-ALU opcodes select ADD.
  function automatic logic [SELW-1:0] ula_select(input logic [3:0] op);
    logic [SELW-1:0] sel;
    case (op)
      OP_ADD:  sel = ULA_ADD;
      OP_AND:  sel = ULA_AND;
      OP_OR:   sel = ULA_OR;
      OP_NOT:  sel = ULA_NOT;
      OP_LDA:  sel = ULA_PASS;
      default: sel = ULA_ADD;
    endcase
    return sel;
  endfunction

  function automatic logic is_jump(input logic [3:0] op);
    logic j;
    case (op)
      OP_JMP, OP_JN, OP_JZ: j = 1'b1;
      default:              j = 1'b0;
    endcase
    return j;
  endfunction

  state_t          state_r;
  state_t          next_s;
  strobe_t         strb_r;
  logic [SELW-1:0] sel_ula_r;
  logic            run_r;
  logic            fetch_go_s;
  logic [3:0]      op_s;

  assign op_s = opcode[3:0];

  // run_r keeps the first post-reset cycle in F_ADDR so the reset cycle itself is strobe-free.
`ifdef NEANDER_CTRL_STEP_EN
  assign fetch_go_s = run_r & step;
`else
  assign fetch_go_s = run_r;
`endif

  // Next-state selection.
  always_comb begin
    next_s = state_r;
    case (state_r)
      S_F_ADDR: begin
        if (fetch_go_s) next_s = S_F_READ;
        else            next_s = S_F_ADDR;
      end
      S_F_READ: next_s = S_F_RDM;
      S_F_RDM:  next_s = S_F_RI;
      S_F_RI:   next_s = S_DECODE;
      S_DECODE: begin
        case (op_s)
          OP_HLT: next_s = S_HALT;
          OP_NOT: next_s = S_EXEC;
          OP_STA, OP_LDA, OP_ADD, OP_OR, OP_AND, OP_JMP: next_s = S_O_ADDR;
          OP_JN: begin
            if (flag_n) next_s = S_O_ADDR;
            else        next_s = S_SKIP;
          end
          OP_JZ: begin
            if (flag_z) next_s = S_O_ADDR;
            else        next_s = S_SKIP;
          end
          default: next_s = S_F_ADDR;
        endcase
      end
      S_O_ADDR: next_s = S_O_READ;
      S_O_READ: next_s = S_O_RDM;
      S_O_RDM: begin
        if (is_jump(op_s)) next_s = S_JUMP;
        else               next_s = S_D_ADDR;
      end
      S_D_ADDR: begin
        if (op_s == OP_STA) next_s = S_D_WDATA;
        else                next_s = S_D_READ;
      end
      S_D_READ:  next_s = S_D_RDM;
      S_D_RDM:   next_s = S_EXEC;
      S_D_WDATA: next_s = S_D_WRITE;
      S_D_WRITE: next_s = S_F_ADDR;
      S_EXEC:    next_s = S_F_ADDR;
      S_JUMP:    next_s = S_F_ADDR;
      S_SKIP:    next_s = S_F_ADDR;
      S_HALT:    next_s = S_HALT;
      default:   next_s = S_F_ADDR;
    endcase
  end

  // State and output registers; strobes are loaded with the pattern of the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= S_F_ADDR;
      strb_r    <= '0;
      sel_ula_r <= ULA_ADD;
      run_r     <= 1'b0;
    end else begin
      state_r   <= next_s;
      strb_r    <= state_strobes(next_s);
      sel_ula_r <= ula_select(op_s);
      run_r     <= 1'b1;
    end
  end

`ifdef NEANDER_CTRL_STEP_EN
  assign step_wait = (state_r == S_F_ADDR) & ~step;
  assign rem_load  = strb_r.rem_load & ~step_wait;
`else
  assign rem_load  = strb_r.rem_load;
`endif

  assign pc_inc    = strb_r.pc_inc;
  assign pc_load   = strb_r.pc_load;
  assign rem_sel   = strb_r.rem_sel;
  assign rdm_load  = strb_r.rdm_load;
  assign rdm_sel   = strb_r.rdm_sel;
  assign mem_write = strb_r.mem_write;
  assign ri_load   = strb_r.ri_load;
  assign ac_load   = strb_r.ac_load;
  assign nz_load   = strb_r.nz_load;
  assign halted    = strb_r.halted;
  assign sel_ula   = sel_ula_r;

endmodule
